lock_sequencer: RTL and testbench
=================================

LOCK_SEQUENCER -- requirements
Module: lock_sequencer

Interface
REQ-001 Parameter CODE_LEN, default 5: digits per entry attempt.
REQ-002 Parameter MAX_FAILS, default 3: consecutive failures that trigger lockout.
REQ-003 Parameter LOCKOUT_CYCLES, default 16: lockout duration in clocks.
REQ-004 Parameter OPEN_CYCLES, default 8: unlocked hold duration in clocks.
REQ-005 Parameter TIMEOUT_CYCLES, default 32: maximum idle gap between digits within one attempt.
REQ-006 Parameter RESET_CODE, default 5'b01011: code after reset; MSB is the first digit entered.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst  in  1  reset; synchronous, active-high.
REQ-009 digit_valid  in  1  one digit is presented this cycle.
REQ-010 digit  in  1  digit value (0 or 1), qualified by digit_valid.
REQ-011 cfg_we  in  1  code-write strobe.
REQ-012 cfg_code  in  CODE_LEN  new code, MSB first digit.
REQ-013 unlocked  out  1  lock is open.
REQ-014 locked_out  out  1  entry disabled after repeated failures.
REQ-015 fail_count  out  2  consecutive failed attempts.
REQ-016 state  out  3  encoded current state.

Function
REQ-017 States and encodings: IDLE=0, ENTRY=1, CHECK=2, OPEN=3, FAIL=4, LOCKOUT=5; all outputs registered.
REQ-018 IDLE: digit_valid loads digit into the entry shift register, sets digit count to 1, and moves to ENTRY (to CHECK if CODE_LEN=1).
REQ-019 ENTRY: each digit_valid shifts digit in at the LSB and increments the count; the digit making count==CODE_LEN moves to CHECK on the next edge.
REQ-020 ENTRY: the gap timer clears on every digit_valid; TIMEOUT_CYCLES consecutive cycles without digit_valid discard the partial entry and move to FAIL.
REQ-021 CHECK lasts exactly one cycle: entry==code moves to OPEN and clears fail_count; mismatch moves to FAIL.
REQ-022 Latency: last digit sampled at edge n; state=CHECK after edge n+1; unlocked=1 after edge n+2.
REQ-023 OPEN: unlocked=1 for exactly OPEN_CYCLES cycles, then IDLE with unlocked=0.
REQ-024 FAIL lasts one cycle and increments fail_count (saturating at MAX_FAILS); if the new value equals MAX_FAILS, the next state is LOCKOUT, otherwise IDLE.
REQ-025 LOCKOUT: locked_out=1 for exactly LOCKOUT_CYCLES cycles, then IDLE with locked_out=0 and fail_count=0.
REQ-026 digit_valid in CHECK, OPEN, FAIL or LOCKOUT is ignored; it is not buffered and does not start an entry.
REQ-027 cfg_we is honoured only in OPEN; stored code = cfg_code from the next cycle; cfg_we in any other state is ignored.
REQ-028 cfg_we and the final OPEN cycle coincide: the write is accepted, then IDLE.
REQ-029 Success clears fail_count; fail_count persists across IDLE between attempts.
REQ-030 unlocked and locked_out are never both 1.

Reset
REQ-031 rst takes priority over all inputs in any state, including mid-entry, OPEN and LOCKOUT.
REQ-032 After reset: state=IDLE, unlocked=0, locked_out=0, fail_count=0, digit count, gap timer and hold timer = 0, code=RESET_CODE, entry register=0.

Structure
REQ-033 The state encoding and the parameter defaults are defined in the shared package lock_pkg.
REQ-034 The single sub-module lock_timer (loadable down-counter with done flag) is shared by the gap, OPEN and LOCKOUT timing.

Verification
REQ-035 Reset, then digits 0,1,0,1,1 on consecutive cycles -> CHECK 1 cycle after the last digit; unlocked=1 for 8 cycles, then state=IDLE.
REQ-036 Digits 1,1,1,1,1 three times -> fail_count 1,2, then LOCKOUT; locked_out=1 for 16 cycles; digits during lockout ignored; then fail_count=0.
REQ-037 Digits 0,1 then 32 idle cycles -> FAIL, fail_count=1; a following correct 01011 -> OPEN, fail_count=0.
REQ-038 In OPEN, cfg_we with cfg_code=5'b10010 -> 01011 then fails and 10010 unlocks; cfg_we in IDLE leaves the code unchanged.
REQ-039 rst asserted after 3 of 5 digits, and separately mid-LOCKOUT -> next cycle all outputs at reset values; 01011 then unlocks.
REQ-040 Digits 0,1,0 with gaps of 31 idle cycles, then 1,1 -> no timeout; unlock succeeds.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared definitions for the lock sequencer: state encoding, parameter
// defaults and a small helper used to size the shared timer.
package lock_pkg;

   localparam int CODE_LEN_DEF       = 5;
   localparam int MAX_FAILS_DEF      = 3;
   localparam int LOCKOUT_CYCLES_DEF = 16;
   localparam int OPEN_CYCLES_DEF    = 8;
   localparam int TIMEOUT_CYCLES_DEF = 32;
   localparam logic [4:0] RESET_CODE_DEF = 5'b01011;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_ENTRY   = 3'd1;
   localparam logic [2:0] ST_CHECK   = 3'd2;
   localparam logic [2:0] ST_OPEN    = 3'd3;
   localparam logic [2:0] ST_FAIL    = 3'd4;
   localparam logic [2:0] ST_LOCKOUT = 3'd5;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the digit gap, OPEN hold and LOCKOUT
// timing. The count stops at zero; done is high while the count is zero.
module lock_timer #(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             tick,
   output logic             done
);

   logic [WIDTH-1:0] count;

   // Load takes precedence over counting down; the counter parks at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (tick && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/lock_sequencer.sv
// Digit-entry combination lock. Digits are shifted into an entry register,
// compared against the stored code, and the result opens the lock for a
// fixed hold time or counts as a failure; repeated failures lock entry out.
module lock_sequencer
   import lock_pkg::*;
#(
   parameter int CODE_LEN       = CODE_LEN_DEF,
   parameter int MAX_FAILS      = MAX_FAILS_DEF,
   parameter int LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEF,
   parameter int OPEN_CYCLES    = OPEN_CYCLES_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter logic [CODE_LEN-1:0] RESET_CODE = CODE_LEN'(RESET_CODE_DEF)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                digit_valid,
   input  logic                digit,
   input  logic                cfg_we,
   input  logic [CODE_LEN-1:0] cfg_code,
   output logic                unlocked,
   output logic                locked_out,
   output logic [1:0]          fail_count,
   output logic [2:0]          state
);

   localparam int CNT_W   = $clog2(CODE_LEN + 1);
   localparam int TIMER_W = $clog2(max3(LOCKOUT_CYCLES, OPEN_CYCLES, TIMEOUT_CYCLES) + 1);

   // Timers are loaded with duration-1 so the state holds for exactly the duration.
   localparam logic [TIMER_W-1:0] GAP_LOAD  = TIMER_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TIMER_W-1:0] OPEN_LOAD = TIMER_W'(OPEN_CYCLES - 1);
   localparam logic [TIMER_W-1:0] LOCK_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);
   localparam logic [1:0]         MAX_FC    = 2'(MAX_FAILS);
   localparam logic [CNT_W-1:0]   FULL_CNT  = CNT_W'(CODE_LEN);

   logic [2:0]          state_next;
   logic [CODE_LEN-1:0] entry, entry_next;
   logic [CNT_W-1:0]    cnt, cnt_next;
   logic [CODE_LEN-1:0] code, code_next;
   logic [1:0]          fail_next, fail_inc;
   logic                t_load, t_tick, t_done;
   logic [TIMER_W-1:0]  t_value;

   lock_timer #(
      .WIDTH(TIMER_W)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .load      (t_load),
      .load_value(t_value),
      .tick      (t_tick),
      .done      (t_done)
   );

   // Next-state, datapath and timer control for every state.
   always_comb begin
      state_next = state;
      entry_next = entry;
      cnt_next   = cnt;
      code_next  = code;
      fail_next  = fail_count;
      fail_inc   = (fail_count == MAX_FC) ? fail_count : fail_count + 2'd1;
      t_load     = 1'b0;
      t_value    = '0;
      t_tick     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (digit_valid) begin
               entry_next = CODE_LEN'(digit);
               cnt_next   = CNT_W'(1);
               t_load     = 1'b1;
               t_value    = GAP_LOAD;
               state_next = (CODE_LEN == 1) ? ST_CHECK : ST_ENTRY;
            end
         end
         ST_ENTRY: begin
            if (cnt == FULL_CNT) begin
               state_next = ST_CHECK;
            end else if (digit_valid) begin
               entry_next = (entry << 1) | CODE_LEN'(digit);
               cnt_next   = cnt + 1'b1;
               t_load     = 1'b1;
               t_value    = GAP_LOAD;
            end else if (t_done) begin
               entry_next = '0;
               cnt_next   = '0;
               state_next = ST_FAIL;
            end else begin
               t_tick = 1'b1;
            end
         end
         ST_CHECK: begin
            cnt_next = '0;
            if (entry == code) begin
               fail_next  = '0;
               t_load     = 1'b1;
               t_value    = OPEN_LOAD;
               state_next = ST_OPEN;
            end else begin
               state_next = ST_FAIL;
            end
         end
         ST_OPEN: begin
            if (cfg_we) begin
               code_next = cfg_code;
            end
            if (t_done) begin
               state_next = ST_IDLE;
            end else begin
               t_tick = 1'b1;
            end
         end
         ST_FAIL: begin
            fail_next = fail_inc;
            if (fail_inc == MAX_FC) begin
               t_load     = 1'b1;
               t_value    = LOCK_LOAD;
               state_next = ST_LOCKOUT;
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_LOCKOUT: begin
            if (t_done) begin
               fail_next  = '0;
               state_next = ST_IDLE;
            end else begin
               t_tick = 1'b1;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; the flag outputs are registered from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         entry      <= '0;
         cnt        <= '0;
         code       <= RESET_CODE;
         fail_count <= '0;
         unlocked   <= 1'b0;
         locked_out <= 1'b0;
      end else begin
         state      <= state_next;
         entry      <= entry_next;
         cnt        <= cnt_next;
         code       <= code_next;
         fail_count <= fail_next;
         unlocked   <= (state_next == ST_OPEN);
         locked_out <= (state_next == ST_LOCKOUT);
      end
   end

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed bench for lock_sequencer: a table of stimulus/expectation
// records followed by hand-written sequences for configuration and reset.
module tb_lock_sequencer;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ENTRY   = 3'd1;
   localparam logic [2:0] S_CHECK   = 3'd2;
   localparam logic [2:0] S_OPEN    = 3'd3;
   localparam logic [2:0] S_FAIL    = 3'd4;
   localparam logic [2:0] S_LOCKOUT = 3'd5;

   logic       clk = 1'b0;
   logic       rst;
   logic       digit_valid;
   logic       digit;
   logic       cfg_we;
   logic [4:0] cfg_code;
   logic       unlocked;
   logic       locked_out;
   logic [1:0] fail_count;
   logic [2:0] state;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      string      name;
      logic       rst;
      logic       dv;
      logic       d;
      logic       we;
      logic [4:0] code;
      int         reps;
      logic [2:0] st;
      logic       unl;
      logic       lo;
      logic [1:0] fc;
   } vec_t;

   vec_t vecs[$];

   lock_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .digit_valid(digit_valid),
      .digit      (digit),
      .cfg_we     (cfg_we),
      .cfg_code   (cfg_code),
      .unlocked   (unlocked),
      .locked_out (locked_out),
      .fail_count (fail_count),
      .state      (state)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Hold the inputs for reps rising edges, then return to quiet inputs 1 unit after the last edge.
   task automatic apply_stimulus(input logic r, input logic dv, input logic d,
                                 input logic we, input logic [4:0] c, input int reps);
      rst         = r;
      digit_valid = dv;
      digit       = d;
      cfg_we      = we;
      cfg_code    = c;
      repeat (reps) begin
         @(posedge clk);
         #1;
      end
      rst         = 1'b0;
      digit_valid = 1'b0;
      digit       = 1'b0;
      cfg_we      = 1'b0;
   endtask

   task automatic check_output(input string name, input logic [2:0] st, input logic unl,
                               input logic lo, input logic [1:0] fc);
      compared++;
      if ({state, unlocked, locked_out, fail_count} !== {st, unl, lo, fc}) begin
         mismatched++;
         $display("[TB] FAIL %s: got state=%0d unlocked=%b locked_out=%b fail_count=%0d, expected state=%0d unlocked=%b locked_out=%b fail_count=%0d",
                  name, state, unlocked, locked_out, fail_count, st, unl, lo, fc);
      end
   endtask

   function automatic void add_vec(input string n, input logic r, input logic dv, input logic d,
                                   input logic we, input logic [4:0] c, input int reps,
                                   input logic [2:0] st, input logic unl, input logic lo,
                                   input logic [1:0] fc);
      vec_t v;
      v.name = n; v.rst = r; v.dv = dv; v.d = d; v.we = we; v.code = c;
      v.reps = reps; v.st = st; v.unl = unl; v.lo = lo; v.fc = fc;
      vecs.push_back(v);
   endfunction

   // Five digit vectors, MSB first; the state stays ENTRY through the last digit.
   function automatic void add_code(input string n, input logic [4:0] c, input logic [1:0] fc);
      for (int i = 4; i >= 0; i--) begin
         add_vec(n, 1'b0, 1'b1, c[i], 1'b0, 5'd0, 1, S_ENTRY, 1'b0, 1'b0, fc);
      end
   endfunction

   function automatic void add_idle(input string n, input int reps, input logic [2:0] st,
                                    input logic unl, input logic lo, input logic [1:0] fc);
      add_vec(n, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, reps, st, unl, lo, fc);
   endfunction

   task automatic enter_code(input logic [4:0] c);
      for (int i = 4; i >= 0; i--) begin
         apply_stimulus(1'b0, 1'b1, c[i], 1'b0, 5'd0, 1);
      end
   endtask

   task automatic idle(input int n);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, n);
   endtask

   initial begin
      rst = 1'b1; digit_valid = 1'b0; digit = 1'b0; cfg_we = 1'b0; cfg_code = 5'd0;

      // Reset and a correct entry with full OPEN timing.
      add_vec("reset", 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 2, S_IDLE, 1'b0, 1'b0, 2'd0);
      add_code("ok_digit", 5'b01011, 2'd0);
      add_idle("ok_check", 1, S_CHECK, 1'b0, 1'b0, 2'd0);
      add_idle("ok_open_first", 1, S_OPEN, 1'b1, 1'b0, 2'd0);
      add_idle("ok_open_last", 7, S_OPEN, 1'b1, 1'b0, 2'd0);
      add_idle("ok_idle", 1, S_IDLE, 1'b0, 1'b0, 2'd0);

      // Three wrong codes lead to lockout; digits during lockout are ignored.
      add_code("bad1_digit", 5'b11111, 2'd0);
      add_idle("bad1_check", 1, S_CHECK, 1'b0, 1'b0, 2'd0);
      add_idle("bad1_fail", 1, S_FAIL, 1'b0, 1'b0, 2'd0);
      add_idle("bad1_idle", 1, S_IDLE, 1'b0, 1'b0, 2'd1);
      add_code("bad2_digit", 5'b11111, 2'd1);
      add_idle("bad2_check", 1, S_CHECK, 1'b0, 1'b0, 2'd1);
      add_idle("bad2_fail", 1, S_FAIL, 1'b0, 1'b0, 2'd1);
      add_idle("bad2_idle", 1, S_IDLE, 1'b0, 1'b0, 2'd2);
      add_code("bad3_digit", 5'b11111, 2'd2);
      add_idle("bad3_check", 1, S_CHECK, 1'b0, 1'b0, 2'd2);
      add_idle("bad3_fail", 1, S_FAIL, 1'b0, 1'b0, 2'd2);
      add_idle("lockout_first", 1, S_LOCKOUT, 1'b0, 1'b1, 2'd3);
      add_vec("lockout_digits", 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 14, S_LOCKOUT, 1'b0, 1'b1, 2'd3);
      add_vec("lockout_last", 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1, S_LOCKOUT, 1'b0, 1'b1, 2'd3);
      add_idle("lockout_exit", 1, S_IDLE, 1'b0, 1'b0, 2'd0);
      add_idle("no_buffered_digit", 1, S_IDLE, 1'b0, 1'b0, 2'd0);

      // Partial entry then 32 idle cycles times out.
      add_vec("to_digit0", 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1, S_ENTRY, 1'b0, 1'b0, 2'd0);
      add_vec("to_digit1", 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1, S_ENTRY, 1'b0, 1'b0, 2'd0);
      add_idle("to_gap31", 31, S_ENTRY, 1'b0, 1'b0, 2'd0);
      add_idle("to_gap32", 1, S_FAIL, 1'b0, 1'b0, 2'd0);
      add_idle("to_idle", 1, S_IDLE, 1'b0, 1'b0, 2'd1);
      add_code("to_retry_digit", 5'b01011, 2'd1);
      add_idle("to_retry_check", 1, S_CHECK, 1'b0, 1'b0, 2'd1);
      add_idle("to_retry_open", 1, S_OPEN, 1'b1, 1'b0, 2'd0);
      add_idle("to_retry_idle", 8, S_IDLE, 1'b0, 1'b0, 2'd0);

      // Gaps of 31 idle cycles do not time out.
      add_vec("gap_d0", 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1, S_ENTRY, 1'b0, 1'b0, 2'd0);
      add_idle("gap_w0", 31, S_ENTRY, 1'b0, 1'b0, 2'd0);
      add_vec("gap_d1", 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1, S_ENTRY, 1'b0, 1'b0, 2'd0);
      add_idle("gap_w1", 31, S_ENTRY, 1'b0, 1'b0, 2'd0);
      add_vec("gap_d2", 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1, S_ENTRY, 1'b0, 1'b0, 2'd0);
      add_idle("gap_w2", 31, S_ENTRY, 1'b0, 1'b0, 2'd0);
      add_vec("gap_d3", 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1, S_ENTRY, 1'b0, 1'b0, 2'd0);
      add_vec("gap_d4", 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1, S_ENTRY, 1'b0, 1'b0, 2'd0);
      add_idle("gap_check", 1, S_CHECK, 1'b0, 1'b0, 2'd0);
      add_idle("gap_open", 1, S_OPEN, 1'b1, 1'b0, 2'd0);
      add_idle("gap_idle", 8, S_IDLE, 1'b0, 1'b0, 2'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         apply_stimulus(vecs[i].rst, vecs[i].dv, vecs[i].d, vecs[i].we, vecs[i].code, vecs[i].reps);
         check_output(vecs[i].name, vecs[i].st, vecs[i].unl, vecs[i].lo, vecs[i].fc);
      end

      // Code change while OPEN: old code fails, new code opens.
      enter_code(5'b01011);
      idle(2);
      check_output("cfg_open", S_OPEN, 1'b1, 1'b0, 2'd0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'b10010, 1);
      check_output("cfg_write_open", S_OPEN, 1'b1, 1'b0, 2'd0);
      idle(7);
      check_output("cfg_open_done", S_IDLE, 1'b0, 1'b0, 2'd0);
      enter_code(5'b01011);
      idle(2);
      check_output("old_code_fail", S_FAIL, 1'b0, 1'b0, 2'd0);
      idle(1);
      check_output("old_code_idle", S_IDLE, 1'b0, 1'b0, 2'd1);
      enter_code(5'b10010);
      idle(2);
      check_output("new_code_open", S_OPEN, 1'b1, 1'b0, 2'd0);
      idle(7);
      check_output("new_code_last_open", S_OPEN, 1'b1, 1'b0, 2'd0);

      // Write on the final OPEN cycle is kept; a write in IDLE is ignored.
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'b11100, 1);
      check_output("final_cycle_write", S_IDLE, 1'b0, 1'b0, 2'd0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'b01011, 1);
      check_output("idle_write", S_IDLE, 1'b0, 1'b0, 2'd0);
      enter_code(5'b11100);
      idle(2);
      check_output("late_write_open", S_OPEN, 1'b1, 1'b0, 2'd0);
      idle(8);

      // Reset mid-entry clears fail_count and restores the reset code.
      enter_code(5'b11111);
      idle(3);
      check_output("pre_reset_fail", S_IDLE, 1'b0, 1'b0, 2'd1);
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1);
      apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1);
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1);
      check_output("mid_entry", S_ENTRY, 1'b0, 1'b0, 2'd1);
      apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1);
      check_output("reset_mid_entry", S_IDLE, 1'b0, 1'b0, 2'd0);
      enter_code(5'b01011);
      idle(2);
      check_output("reset_code_open", S_OPEN, 1'b1, 1'b0, 2'd0);
      idle(8);
      check_output("reset_code_idle", S_IDLE, 1'b0, 1'b0, 2'd0);

      // Reset mid-lockout.
      for (int k = 0; k < 3; k++) begin
         enter_code(5'b11111);
         idle(3);
      end
      check_output("lockout_again", S_LOCKOUT, 1'b0, 1'b1, 2'd3);
      idle(5);
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1);
      check_output("reset_mid_lockout", S_IDLE, 1'b0, 1'b0, 2'd0);
      enter_code(5'b01011);
      idle(2);
      check_output("after_lockout_open", S_OPEN, 1'b1, 1'b0, 2'd0);
      idle(8);
      check_output("after_lockout_idle", S_IDLE, 1'b0, 1'b0, 2'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
